// File: rtl/mod_addsub_pipe.sv
// mod_addsub_pipe: multi-lane modular add/sub butterfly pipeline with clock-enable stall and tag sideband
module mod_addsub_pipe #(
  parameter int         W     = 64,
  parameter logic [W:0] P     = (W+1)'(64'hFFFFFFFF00000001),
  parameter int         LANES = 1,
  parameter int         DEPTH = 6,
  parameter int         TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [1:0]           in_op,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [LANES*W-1:0]   in_a,
  input  logic [LANES*W-1:0]   in_b,
  output logic                 out_valid,
  output logic [TAG_W-1:0]     out_tag,
  output logic [LANES*W-1:0]   out_0,
  output logic [LANES*W-1:0]   out_1
);

  if (DEPTH < 2 || !P[0] || P[W] || P <= 2) begin : g_bad
    $error("mod_addsub_pipe: DEPTH must be >= 2 and P odd with 2 < P < 2^W");
  end

  logic [W:0]           w_s  [LANES];
  logic [W:0]           w_d  [LANES];
  logic [W-1:0]         w_sm [LANES];
  logic [W-1:0]         w_dm [LANES];
  logic [LANES*W-1:0]   w_o0;
  logic [LANES*W-1:0]   w_o1;

  logic [W:0]           r_s  [LANES];
  logic [W:0]           r_d  [LANES];
  logic [1:0]           r_op;
  logic                 r_v1;
  logic [TAG_W-1:0]     r_tag1;

  logic                 r_v  [DEPTH-1];
  logic [TAG_W-1:0]     r_t  [DEPTH-1];
  logic [LANES*W-1:0]   r_o0 [DEPTH-1];
  logic [LANES*W-1:0]   r_o1 [DEPTH-1];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    assign w_a = in_a[i*W +: W];
    assign w_b = in_b[i*W +: W];
    // reverse butterfly swaps the subtraction operands so stage 2 never needs a negation
    assign w_s[i]  = {1'b0, w_a} + {1'b0, w_b};
    assign w_d[i]  = (in_op == 2'b11) ? {1'b0, w_b} - {1'b0, w_a} : {1'b0, w_a} - {1'b0, w_b};
    // a single conditional correction suffices because canonical inputs bound s < 2P and |d| < P
    assign w_sm[i] = (r_s[i] >= P) ? W'(r_s[i] - P) : r_s[i][W-1:0];
    assign w_dm[i] = r_d[i][W] ? W'(r_d[i] + P) : r_d[i][W-1:0];
    assign w_o0[i*W +: W] = (r_op == 2'b10) ? w_dm[i] : w_sm[i];
    assign w_o1[i*W +: W] = (r_op[0] ^ r_op[1]) ? '0 : w_dm[i];
  end

  // stage 1: raw W+1-bit sum and difference per lane, plus beat control
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_v1   <= 1'b0;
      r_op   <= '0;
      r_tag1 <= '0;
      for (int k = 0; k < LANES; k++) begin
        r_s[k] <= '0;
        r_d[k] <= '0;
      end
    end else if (ce) begin
      r_v1   <= in_valid;
      r_op   <= in_op;
      r_tag1 <= in_tag;
      for (int k = 0; k < LANES; k++) begin
        r_s[k] <= w_s[k];
        r_d[k] <= w_d[k];
      end
    end

  // stage 2 captures the corrected, op-selected results; later entries are retiming delay
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < DEPTH-1; k++) begin
        r_v[k]  <= 1'b0;
        r_t[k]  <= '0;
        r_o0[k] <= '0;
        r_o1[k] <= '0;
      end
    end else if (ce) begin
      r_v[0]  <= r_v1;
      r_t[0]  <= r_tag1;
      r_o0[0] <= w_o0;
      r_o1[0] <= w_o1;
      for (int k = 1; k < DEPTH-1; k++) begin
        r_v[k]  <= r_v[k-1];
        r_t[k]  <= r_t[k-1];
        r_o0[k] <= r_o0[k-1];
        r_o1[k] <= r_o1[k-1];
      end
    end

  assign out_valid = r_v[DEPTH-2];
  assign out_tag   = r_t[DEPTH-2];
  assign out_0     = r_o0[DEPTH-2];
  assign out_1     = r_o1[DEPTH-2];

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// tb_mod_addsub_pipe: scoreboard bench for the default 64-bit config and a 4-lane 16-bit config
module tb_mod_addsub_pipe;
  localparam logic [63:0] PA = 64'hFFFFFFFF00000001;
  localparam logic [63:0] PB = 64'd65521;

  typedef struct {
    logic [7:0]  tag;
    logic [63:0] o0;
    logic [63:0] o1;
    int          at;
  } exp_t;

  logic clk = 0, rst = 1;
  logic ce0 = 0, iv0 = 0, ce1 = 1, iv1 = 0;
  logic [1:0] op0 = 0, op1 = 0;
  logic [7:0] it0 = 0, it1 = 0;
  logic [63:0] ia0 = 0, ib0 = 0, ia1 = 0, ib1 = 0;
  logic ov0, ov1;
  logic [7:0] ot0, ot1;
  logic [63:0] oa0, ob0, oa1, ob1;

  exp_t q0[$], q1[$];
  exp_t e0, e1, s0, s1;
  int n_chk = 0, n_pass = 0, ce_n0 = 0, ce_n1 = 0;
  bit hit0 = 0, hit1 = 0, rev = 1;
  logic [8:0] pvt0, pvt1;
  logic [63:0] pa0, pb0, pa1, pb1;

  always #5 clk = ~clk;

  mod_addsub_pipe u0 (
    .clk(clk), .rst(rst), .ce(ce0), .in_valid(iv0), .in_op(op0), .in_tag(it0),
    .in_a(ia0), .in_b(ib0), .out_valid(ov0), .out_tag(ot0), .out_0(oa0), .out_1(ob0));

  mod_addsub_pipe #(.W(16), .P(17'd65521), .LANES(4), .DEPTH(2), .TAG_W(8)) u1 (
    .clk(clk), .rst(rst), .ce(ce1), .in_valid(iv1), .in_op(op1), .in_tag(it1),
    .in_a(ia1), .in_b(ib1), .out_valid(ov1), .out_tag(ot1), .out_0(oa1), .out_1(ob1));

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, req);
  endfunction

  function automatic logic [63:0] model(int d, logic [1:0] op, logic [63:0] a, logic [63:0] b, bit sec);
    int w = d ? 16 : 64;
    int l = d ? 4 : 1;
    logic [127:0] p = d ? {64'd0, PB} : {64'd0, PA};
    logic [127:0] m = (128'd1 << w) - 1;
    logic [127:0] x, y, s, dab, dba, v;
    logic [63:0] r = 0;
    for (int i = 0; i < l; i++) begin
      x   = ({64'd0, a} >> (i*w)) & m;
      y   = ({64'd0, b} >> (i*w)) & m;
      s   = (x + y) % p;
      dab = (x + p - y) % p;
      dba = (y + p - x) % p;
      v   = sec ? (op == 2'b00 ? dab : op == 2'b11 ? dba : 128'd0) : (op == 2'b10 ? dab : s);
      r   = r | 64'(v << (i*w));
    end
    return r;
  endfunction

  function automatic logic [63:0] pick(logic [63:0] p);
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return p - 1;
      2: return p - 2;
      3: return 64'd1;
      default: return {$urandom, $urandom} % p;
    endcase
  endfunction

  function automatic logic [63:0] rnd(int d);
    logic [63:0] r = 0;
    if (d == 0) return pick(PA);
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'(pick(PB));
    return r;
  endfunction

  // input sampler: every ce-enabled edge out of reset captures a beat into the expectation queue
  always @(posedge clk) begin
    hit0 = ce0 && !rst;
    hit1 = ce1 && !rst;
    if (hit0) begin
      ce_n0++;
      if (iv0) begin
        s0.tag = it0; s0.o0 = model(0, op0, ia0, ib0, 0); s0.o1 = model(0, op0, ia0, ib0, 1); s0.at = ce_n0 + 5;
        q0.push_back(s0);
      end
    end
    if (hit1) begin
      ce_n1++;
      if (iv1) begin
        s1.tag = it1; s1.o0 = model(1, op1, ia1, ib1, 0); s1.o1 = model(1, op1, ia1, ib1, 1); s1.at = ce_n1 + 1;
        q1.push_back(s1);
      end
    end
  end

  // output monitor: compares emerging beats against the queue and checks outputs hold while ce is low
  always @(negedge clk) begin
    if (hit0 && ov0) begin
      if (q0.size() == 0) chk("d0_unexpected_valid", 64'(ov0), 64'd0);
      else begin
        e0 = q0.pop_front();
        chk("d0_tag", 64'(ot0), 64'(e0.tag));
        chk("d0_out0", oa0, e0.o0);
        chk("d0_out1", ob0, e0.o1);
        chk("d0_latency", 64'(ce_n0), 64'(e0.at));
      end
    end
    if (hit1 && ov1) begin
      if (q1.size() == 0) chk("d1_unexpected_valid", 64'(ov1), 64'd0);
      else begin
        e1 = q1.pop_front();
        chk("d1_tag", 64'(ot1), 64'(e1.tag));
        chk("d1_out0", oa1, e1.o0);
        chk("d1_out1", ob1, e1.o1);
        chk("d1_latency", 64'(ce_n1), 64'(e1.at));
      end
    end
    if (!rst && !rev) begin
      if (!hit0) begin
        chk("d0_hold_vt", 64'({ov0, ot0}), 64'(pvt0));
        chk("d0_hold_o0", oa0, pa0);
        chk("d0_hold_o1", ob0, pb0);
      end
      if (!hit1) begin
        chk("d1_hold_vt", 64'({ov1, ot1}), 64'(pvt1));
        chk("d1_hold_o0", oa1, pa1);
        chk("d1_hold_o1", ob1, pb1);
      end
    end
    pvt0 = {ov0, ot0}; pa0 = oa0; pb0 = ob0;
    pvt1 = {ov1, ot1}; pa1 = oa1; pb1 = ob1;
    rev = 0;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic zero_chk(string nm);
    chk({nm, "_v0"}, 64'(ov0), 64'd0);
    chk({nm, "_t0"}, 64'(ot0), 64'd0);
    chk({nm, "_a0"}, oa0, 64'd0);
    chk({nm, "_b0"}, ob0, 64'd0);
    chk({nm, "_v1"}, 64'(ov1), 64'd0);
    chk({nm, "_a1"}, oa1, 64'd0);
    chk({nm, "_b1"}, ob1, 64'd0);
  endtask

  task automatic dir0(input logic [1:0] op, input logic [7:0] tg, input logic [63:0] a, b, x0, x1);
    op0 = op; it0 = tg; ia0 = a; ib0 = b; iv0 = 1; ce0 = 1;
    step();
    iv0 = 0;
    repeat (5) step();
    chk("dir0_valid", 64'(ov0), 64'd1);
    chk("dir0_tag", 64'(ot0), 64'(tg));
    chk("dir0_out0", oa0, x0);
    chk("dir0_out1", ob0, x1);
    step();
    chk("dir0_valid_one_cycle", 64'(ov0), 64'd0);
  endtask

  initial begin
    #12;
    zero_chk("reset");
    rst = 0;
    step();
    zero_chk("post_reset_idle");
    dir0(2'b00, 8'h11, PA - 1, 64'd1, 64'd0, 64'hFFFFFFFEFFFFFFFF);
    dir0(2'b00, 8'h12, PA - 1, PA - 1, 64'hFFFFFFFEFFFFFFFF, 64'd0);
    dir0(2'b00, 8'h13, 64'd0, 64'd1, 64'd1, 64'hFFFFFFFF00000000);
    dir0(2'b11, 8'h14, 64'd5, 64'd3, 64'd8, 64'hFFFFFFFEFFFFFFFF);
    dir0(2'b01, 8'h15, 64'd5, 64'd3, 64'd8, 64'd0);
    dir0(2'b10, 8'h16, 64'd5, 64'd3, 64'd2, 64'd0);
    dir0(2'b00, 8'h17, 64'd123, 64'd123, 64'd246, 64'd0);
    dir0(2'b11, 8'h18, 64'd77, 64'd77, 64'd154, 64'd0);
    dir0(2'b00, 8'h19, 64'd0, 64'd0, 64'd0, 64'd0);
    // ten beats under random ce stalls; in_valid stays high while ce is low
    for (int i = 0; i < 10; i++) begin
      op0 = 2'($urandom_range(0, 3)); it0 = 8'(i); ia0 = rnd(0); ib0 = rnd(0); iv0 = 1;
      do begin
        ce0 = 1'($urandom_range(0, 1));
        step();
      end while (!hit0);
    end
    iv0 = 0;
    for (int k = 0; k < 300 && q0.size() > 0; k++) begin
      ce0 = 1'($urandom_range(0, 1));
      step();
    end
    ce0 = 1;
    @(negedge clk); #1;
    chk("d0_stall_drain", 64'(q0.size()), 64'd0);
    // asynchronous reset mid-cycle with four beats in flight
    step();
    for (int i = 0; i < 4; i++) begin
      op0 = 2'b00; it0 = 8'h40 + 8'(i); ia0 = 64'(i + 2); ib0 = 64'd1; iv0 = 1;
      step();
    end
    iv0 = 0;
    #2 rst = 1; rev = 1; q0.delete(); q1.delete();
    #1 zero_chk("async_reset");
    #4 rst = 0; rev = 1;
    dir0(2'b00, 8'h55, 64'd7, 64'd3, 64'd10, 64'd4);
    repeat (8) step();
    chk("d0_no_stale", 64'(q0.size()), 64'd0);
    // 4-lane 16-bit configuration
    ia1 = {16'd65520, 16'd7, 16'd0, 16'd65520};
    ib1 = {16'd0, 16'd7, 16'd1, 16'd65520};
    op1 = 2'b00; it1 = 8'hA5; iv1 = 1; ce1 = 1;
    step();
    iv1 = 0;
    step();
    chk("dir1_valid", 64'(ov1), 64'd1);
    chk("dir1_tag", 64'(ot1), 64'hA5);
    chk("dir1_out0", oa1, {16'd65520, 16'd14, 16'd1, 16'd65519});
    chk("dir1_out1", ob1, {16'd65520, 16'd0, 16'd65520, 16'd0});
    step();
    chk("dir1_valid_one_cycle", 64'(ov1), 64'd0);
    for (int n = 0; n < 10000; n++) begin
      iv1 = ($urandom_range(0, 3) != 0); op1 = 2'($urandom_range(0, 3)); it1 = 8'($urandom_range(0, 255));
      ia1 = rnd(1); ib1 = rnd(1); ce1 = ($urandom_range(0, 4) != 0);
      step();
    end
    iv1 = 0; ce1 = 1;
    repeat (3) step();
    @(negedge clk); #1;
    chk("d1_random_drain", 64'(q1.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
